// File: rtl/sr_driver.sv
// -----------------------------------------------------------------------------
// sr_driver
//
// Drives an external SR flop to a requested level. A request is accepted in
// IDLE, the selected drive line (s for level 1, r for level 0) is held high for
// PULSE_W cycles, then q_fb is watched for up to TIMEOUT cycles. A match ends
// the command with a one-cycle done pulse; running out of time ends it with a
// one-cycle err pulse.
//
// Optional feature macro: SR_DRIVER_SKIP_EN
//   When defined, a request whose level already equals q_fb at acceptance is
//   completed immediately (done next cycle, no drive pulse, req_ready low in
//   that done cycle). When undefined, every request runs PULSE and CHECK.
//
// Parameters:
//   PULSE_W  : cycles s or r is held high per command (1..255)
//   TIMEOUT  : maximum CHECK cycles spent waiting for feedback (1..255)
//
// Ports:
//   clk       : clock, all logic on the rising edge
//   rst_n     : synchronous active-low reset
//   req_valid : a level-change request is present
//   req_level : requested level, 1 = set, 0 = reset
//   req_ready : block can accept a request (IDLE only)
//   q_fb      : q fed back from the driven SR flop
//   s, r      : registered set / reset drive, never high together
//   done      : one-cycle pulse on successful completion
//   err       : one-cycle pulse on timeout
// -----------------------------------------------------------------------------
module sr_driver #(
    parameter int PULSE_W = 4,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // One counter times both the drive pulse and the feedback window, so it
    // must hold the larger of the two terminal values.
    localparam int CNT_MAX = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             s_d, r_d, done_d, err_d;
    logic             skip_q, skip_d;
    logic             skip_hit;
    logic             accept;

`ifdef SR_DRIVER_SKIP_EN
    assign skip_hit = (req_level == q_fb);
`else
    assign skip_hit = 1'b0;
`endif

    // A skipped request finishes while the state stays IDLE; the skip flag
    // holds off a new acceptance during its done cycle.
    assign req_ready = (state_q == IDLE) && !skip_q;
    assign accept    = req_valid && req_ready;

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        skip_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    level_d = req_level;
                    cnt_d   = '0;
                    if (skip_hit) begin
                        done_d = 1'b1;
                        skip_d = 1'b1;
                    end else begin
                        state_d = PULSE;
                        s_d     = req_level;
                        r_d     = !req_level;
                    end
                end
            end

            PULSE: begin
                // The drive registered at acceptance is the first pulse cycle,
                // so the last compare value ends it after exactly PULSE_W.
                if (cnt_q == PULSE_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    s_d   = level_q;
                    r_d   = !level_q;
                end
            end

            CHECK: begin
                if (q_fb == level_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: reset is checked inside the clocked block, so it only takes
            // effect on an edge and has priority over any acceptance there.
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            s       <= 1'b0;
            r       <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            s       <= s_d;
            r       <= r_d;
            done    <= done_d;
            err     <= err_d;
            skip_q  <= skip_d;
        end
    end

endmodule
